// File: rtl/fsqrt_norm_pkg.sv
`default_nettype none
// ============================================================================
// Module  : fsqrt_norm_pkg
// Brief   : Shared widths and IEEE single constants for the fsqrt datapath.
// Revision: 1.0 - initial release
// ============================================================================
package fsqrt_norm_pkg;

    localparam int c_mant_w        = 25;
    localparam int c_lz_w          = 5;
    localparam int c_exp_bias      = 127;
    localparam int c_exp_w_default = 10;
    localparam int c_sp_w          = 32;
    localparam int c_sp_exp_w      = 8;
    localparam int c_sp_frac_w     = 23;
    localparam int c_sp_exp_max    = 2 * c_exp_bias + 1;

endpackage
`default_nettype wire

// File: rtl/fsqrt_norm_lzc.sv
`default_nettype none
// ============================================================================
// Module  : lzc
// Brief   : Leading-zero count of the 25-bit unnormalised mantissa.
// Revision: 1.0 - initial release
// ============================================================================
module lzc
    import fsqrt_norm_pkg::*;
(
    input  logic [c_mant_w-1:0] i_mant,
    output logic [c_lz_w-1:0]   o_lz
);

    // Later (higher) set bits overwrite earlier ones; an all-zero input saturates at 24.
    always_comb begin
        o_lz = c_lz_w'(c_mant_w - 1);
        for (int i = 0; i < c_mant_w; i++) begin
            if (i_mant[i]) begin
                o_lz = c_lz_w'(c_mant_w - 1 - i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fsqrt_norm.sv
`default_nettype none
// ============================================================================
// Module  : fsqrt_norm
// Brief   : Two-stage normalise/round/pack pipeline producing IEEE singles.
// Revision: 1.0 - initial release
// ============================================================================
module fsqrt_norm
    import fsqrt_norm_pkg::*;
#(
    parameter int EXP_W = c_exp_w_default
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_sign,
    input  logic [EXP_W-1:0]     in_exp,
    input  logic [c_mant_w-1:0]  in_mant,
    input  logic                 in_sticky,
    input  logic                 in_special,
    input  logic [c_sp_w-1:0]    in_special_val,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [c_sp_w-1:0]    out_data
);

    localparam int c_ew = EXP_W + 2;

    logic                 r_s1_valid;
    logic                 r_s2_valid;
    logic                 r_s1_sign;
    logic                 r_s1_sticky;
    logic                 r_s1_special;
    logic [EXP_W-1:0]     r_s1_exp;
    logic [c_mant_w-1:0]  r_s1_mant;
    logic [c_sp_w-1:0]    r_s1_special_val;
    logic [c_lz_w-1:0]    r_s1_lz;
    logic [c_sp_w-1:0]    r_out_data;

    logic                 w_s2_adv;
    logic                 w_in_fire;
    logic [c_lz_w-1:0]    w_lz;

    logic [c_mant_w-1:0]  w_m;
    logic [c_sp_frac_w-1:0] w_frac;
    logic                 w_guard;
    logic                 w_round_up;
    logic [c_sp_frac_w:0] w_frac_sum;
    logic                 w_carry;
    logic [c_sp_frac_w-1:0] w_frac_fin;
    logic [c_ew-1:0]      w_lz_ext;
    logic [c_ew-1:0]      w_e_pre;
    logic [c_ew-1:0]      w_e_fin;
    logic                 w_underflow;
    logic                 w_overflow;
    logic [c_sp_w-1:0]    w_result;

    assign w_s2_adv  = !r_s2_valid || out_ready;
    assign in_ready  = !r_s1_valid || w_s2_adv;
    assign w_in_fire = in_valid && in_ready;
    assign out_valid = r_s2_valid;
    assign out_data  = r_out_data;

    lzc u_lzc (
        .i_mant (in_mant),
        .o_lz   (w_lz)
    );

    // Stage 2 datapath: after the shift the hidden one sits at bit 24, so a
    // clear bit 24 means the mantissa was zero.
    always_comb begin
        w_m        = r_s1_mant << r_s1_lz;
        w_frac     = w_m[c_sp_frac_w:1];
        w_guard    = w_m[0];
        w_round_up = w_guard & (r_s1_sticky | w_frac[0]);
        w_frac_sum = {1'b0, w_frac} + {{c_sp_frac_w{1'b0}}, w_round_up};
        w_carry    = w_frac_sum[c_sp_frac_w];
        w_frac_fin = w_carry ? {c_sp_frac_w{1'b0}} : w_frac_sum[c_sp_frac_w-1:0];
        w_lz_ext   = {{(c_ew-c_lz_w){1'b0}}, r_s1_lz};
        w_e_pre    = {{2{r_s1_exp[EXP_W-1]}}, r_s1_exp} + c_ew'(1) - w_lz_ext;
        w_e_fin    = w_e_pre + {{(c_ew-1){1'b0}}, w_carry};
        w_underflow = w_e_fin[c_ew-1] || (w_e_fin == {c_ew{1'b0}});
        w_overflow  = !w_e_fin[c_ew-1] && (w_e_fin >= c_ew'(c_sp_exp_max));

        if (r_s1_special) begin
            w_result = r_s1_special_val;
        end else if (!w_m[c_mant_w-1] || w_underflow) begin
            w_result = {r_s1_sign, {(c_sp_w-1){1'b0}}};
        end else if (w_overflow) begin
            w_result = {r_s1_sign, {c_sp_exp_w{1'b1}}, {c_sp_frac_w{1'b0}}};
        end else begin
            w_result = {r_s1_sign, w_e_fin[c_sp_exp_w-1:0], w_frac_fin};
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
            r_out_data <= '0;
        end else begin
            if (in_ready) begin
                r_s1_valid <= in_valid;
            end
            if (w_s2_adv) begin
                r_s2_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_out_data <= w_result;
                end
            end
        end
    end

    // Payload registers are qualified by r_s1_valid, so they carry no reset.
    always_ff @(posedge clk) begin
        if (w_in_fire) begin
            r_s1_sign        <= in_sign;
            r_s1_exp         <= in_exp;
            r_s1_mant        <= in_mant;
            r_s1_sticky      <= in_sticky;
            r_s1_special     <= in_special;
            r_s1_special_val <= in_special_val;
            r_s1_lz          <= w_lz;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fsqrt_norm.sv
`default_nettype none
// ============================================================================
// Module  : tb_fsqrt_norm
// Brief   : Directed and randomized self-checking bench for fsqrt_norm.
// Revision: 1.0 - initial release
// ============================================================================
module tb_fsqrt_norm;

    logic        clk;
    logic        rstn;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [9:0]  in_exp;
    logic [24:0] in_mant;
    logic        in_sticky;
    logic        in_special;
    logic [31:0] in_special_val;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;

    int          n_vec;
    int          n_err;
    logic [31:0] q[$];
    logic [31:0] cur_exp;
    bit          accepted;
    bit          rand_ready;

    fsqrt_norm #(.EXP_W(10)) dut (
        .clk            (clk),
        .rstn           (rstn),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_sign        (in_sign),
        .in_exp         (in_exp),
        .in_mant        (in_mant),
        .in_sticky      (in_sticky),
        .in_special     (in_special),
        .in_special_val (in_special_val),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Arithmetic reference: locate the leading one, keep a 24-bit significand,
    // round to nearest even, then classify the biased exponent.
    function automatic logic [31:0] ref_model(input logic s, input int e_in,
                                              input logic [24:0] mant, input logic st,
                                              input logic sp, input logic [31:0] sv);
        int          p;
        int          e;
        logic [25:0] kept;
        logic        g;
        if (sp) return sv;
        if (mant == 25'd0) return {s, 31'b0};
        p = 0;
        for (int i = 0; i < 25; i++) if (mant[i]) p = i;
        e = e_in + p - 23;
        if (p == 24) begin
            kept = {1'b0, mant} >> 1;
            g    = mant[0];
        end else begin
            kept = {1'b0, mant} << (23 - p);
            g    = 1'b0;
        end
        if (g && (st || kept[0])) kept = kept + 26'd1;
        if (kept == 26'h1000000) begin
            kept = kept >> 1;
            e    = e + 1;
        end
        if (e <= 0)   return {s, 31'b0};
        if (e >= 255) return {s, 8'hFF, 23'b0};
        return {s, 8'(e), kept[22:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_vec++;
        assert (got === expv) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, got, expv);
        end
    endtask

    // One clock: sample handshakes before the edge, score transfers, check stall hold.
    task automatic tick();
        logic        ov, orr, ir;
        logic [31:0] od, e;
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
        #2;
        ov = out_valid; orr = out_ready; ir = in_ready; od = out_data;
        accepted = in_valid && ir;
        if (accepted) q.push_back(cur_exp);
        if (ov && orr) begin
            if (q.size() == 0) begin
                n_vec++;
                n_err++;
                $error("FAIL spurious_output: observed %h expected no output", od);
            end else begin
                e = q.pop_front();
                chk("out_data", od, e);
            end
        end
        @(posedge clk);
        #1;
        if (ov && !orr) begin
            chk("stall_valid", {31'b0, out_valid}, 32'd1);
            chk("stall_data", out_data, od);
        end
    endtask

    task automatic send(input logic s, input logic [9:0] e, input logic [24:0] m,
                        input logic st, input logic sp, input logic [31:0] sv,
                        input logic [31:0] expv, input bit must_accept);
        in_sign = s; in_exp = e; in_mant = m; in_sticky = st;
        in_special = sp; in_special_val = sv;
        cur_exp = expv;
        in_valid = 1'b1;
        accepted = 1'b0;
        for (int k = 0; k < 64 && !accepted; k++) begin
            tick();
            if (must_accept && k == 0) chk("no_bubble", {31'b0, accepted}, 32'd1);
        end
        if (!accepted) begin
            n_vec++;
            n_err++;
            $error("FAIL accept_timeout: observed in_ready stuck 0 expected accept");
        end
        in_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        for (int k = 0; k < 200 && q.size() != 0; k++) tick();
        chk(tag, q.size(), 32'd0);
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        rstn = 1'b0; in_valid = 1'b0; in_sign = 1'b0; in_exp = '0; in_mant = '0;
        in_sticky = 1'b0; in_special = 1'b0; in_special_val = '0;
        out_ready = 1'b1; rand_ready = 1'b0; cur_exp = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_out_data", out_data, 32'h0);
        rstn = 1'b1;

        // Latency: accepted on one edge, visible after the next.
        send(1'b0, 10'd127, 25'h0800000, 1'b0, 1'b0, 32'h0, 32'h3F800000, 1'b1);
        #2 chk("lat_s1_only", {31'b0, out_valid}, 32'd0);
        tick();
        chk("lat_out_valid", {31'b0, out_valid}, 32'd1);
        drain("drain_latency");

        // Back-to-back directed corner cases.
        send(1'b0, 10'd127, 25'h1000001, 1'b0, 1'b0, 32'h0, 32'h40000000, 1'b1);
        send(1'b0, 10'd127, 25'h1000001, 1'b1, 1'b0, 32'h0, 32'h40000001, 1'b1);
        send(1'b0, 10'd127, 25'h1000003, 1'b0, 1'b0, 32'h0, 32'h40000002, 1'b1);
        // The rounding carry needs a set guard bit, so the all-ones run reaches bit 24.
        send(1'b0, 10'd127, 25'h1FFFFFF, 1'b1, 1'b0, 32'h0, 32'h40800000, 1'b1);
        send(1'b0, 10'd10,  25'h0000001, 1'b0, 1'b0, 32'h0, 32'h00000000, 1'b1);
        send(1'b1, 10'd50,  25'h0000000, 1'b1, 1'b0, 32'h0, 32'h80000000, 1'b1);
        send(1'b0, 10'd300, 25'h0800000, 1'b0, 1'b0, 32'h0, 32'h7F800000, 1'b1);
        send(1'b1, 10'd127, 25'h0800000, 1'b0, 1'b0, 32'h0, 32'hBF800000, 1'b1);
        send(1'b0, 10'd254, 25'h1000000, 1'b0, 1'b0, 32'h0, 32'h7F800000, 1'b1);
        send(1'b0, 10'd253, 25'h1000000, 1'b0, 1'b0, 32'h0, 32'h7F000000, 1'b1);
        send(1'b0, 10'd1,   25'h0800000, 1'b0, 1'b0, 32'h0, 32'h00800000, 1'b1);
        send(1'b1, 10'd0,   25'h0800000, 1'b0, 1'b0, 32'h0, 32'h80000000, 1'b1);
        send(1'b0, 10'h3FB, 25'h1000000, 1'b0, 1'b0, 32'h0, 32'h00000000, 1'b1);
        send(1'b0, 10'd127, 25'h0000000, 1'b0, 1'b1, 32'h7FC00000, 32'h7FC00000, 1'b1);
        drain("drain_directed");

        // Randomized traffic with random backpressure and input gaps.
        rand_ready = 1'b1;
        for (int n = 0; n < 200; n++) begin
            logic        s, st, sp;
            logic [9:0]  e;
            logic [24:0] m;
            logic [31:0] sv;
            s  = 1'($urandom_range(0, 1));
            st = 1'($urandom_range(0, 1));
            sp = ($urandom_range(0, 15) == 0);
            sv = $urandom;
            e  = 10'($urandom_range(0, 420)) - 10'd40;
            m  = 25'($urandom) >> $urandom_range(0, 25);
            send(s, e, m, st, sp, sv, ref_model(s, int'($signed(e)), m, st, sp, sv), 1'b0);
            if ($urandom_range(0, 3) == 0) tick();
        end
        rand_ready = 1'b0;
        out_ready = 1'b1;
        drain("drain_random");

        // Fill both stages under backpressure, then reset mid-flight.
        out_ready = 1'b0;
        send(1'b0, 10'd127, 25'h0800000, 1'b0, 1'b0, 32'h0, 32'h3F800000, 1'b0);
        send(1'b0, 10'd128, 25'h0800000, 1'b0, 1'b0, 32'h0, 32'h40000000, 1'b0);
        rstn = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
        rstn = 1'b1;
        q.delete();
        @(posedge clk);
        #1;
        chk("midrst_in_ready", {31'b0, in_ready}, 32'd1);
        out_ready = 1'b1;
        repeat (6) tick();
        chk("midrst_no_stale", {31'b0, out_valid}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
